// File: rtl/seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : seq_pkg                                                       |
// | Purpose  : Shared types and width helpers for the serial bit source and  |
// |            its FIFO. Holds the shifter state enum, default sizes, and    |
// |            the pointer/counter width helpers PTR_W / CNT_W.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package seq_pkg;

   // Shifter states. The encoding width is fixed so that a corrupted state
   // value is always representable and can be steered back to IDLE.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // PTR_W: FIFO pointer width for a given depth; pointers wrap naturally
   // because the depth is a power of two.
   function automatic int PTR_W(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // CNT_W: bit-counter width for a given word width. The counter only ever
   // reaches WIDTH-1, so $clog2(WIDTH) bits are sufficient.
   function automatic int CNT_W(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sync_fifo                                                     |
// | Purpose  : Single-clock FIFO with registered storage, natural-wrapping   |
// |            pointers and an occupancy counter. Read data is the entry at  |
// |            the read pointer (no fall-through: a word becomes visible the |
// |            cycle after it is pushed).                                    |
// | Ports    : clk, reset (async, active-low)                                |
// |            i_push, i_push_data  - write request / data                   |
// |            i_pop                - read request (consumes o_pop_data)     |
// |            o_pop_data           - head entry                             |
// |            o_level              - occupancy 0..DEPTH                     |
// |            o_full, o_empty      - status derived from o_level            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sync_fifo
   import seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int c_PTR_W = PTR_W(DEPTH);
   localparam int c_LVL_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full  = (r_level == c_LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);

   // A push is judged against the current (pre-pop) level, so a full FIFO
   // refuses a write even when a pop happens on the same edge.
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop  & ~o_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage carries no reset: contents are only observable once written.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_level    = r_level;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/serial_bit_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_bit_source                                             |
// | Purpose  : Buffers parallel words in a FIFO and serialises them one bit  |
// |            per clock onto ser_out, back-to-back with no idle gap when    |
// |            data is available. ser_out idles at IDLE_BIT otherwise.       |
// | Ports    : clk        - rising-edge clock                                |
// |            reset      - asynchronous, active-low                         |
// |            wr_data    - word to serialise                                |
// |            wr_valid   - wr_data valid                                    |
// |            wr_ready   - FIFO not full                                    |
// |            ser_out    - registered serial bit                            |
// |            ser_active - 1 while ser_out carries a data bit               |
// |            level      - FIFO occupancy 0..DEPTH                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module serial_bit_source
   import seq_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic                     ser_out,
   output logic                     ser_active,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int            c_CNT_W = CNT_W(WIDTH);
   localparam [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

   // FIFO interface
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [WIDTH-1:0] w_fifo_data;
   logic             w_pop;

   // Shifter state
   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic             r_ser_out;
   logic             w_ser_out_nxt;
   logic             r_ser_active;
   logic             w_ser_active_nxt;
   logic             w_last;

   // Bit-order selection: the first bit of a freshly loaded word, and the
   // next bit / remaining bits of the word held in the shift register.
   logic             w_load_bit;
   logic [WIDTH-1:0] w_load_rest;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_next_rest;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (wr_valid),
      .i_push_data (wr_data),
      .i_pop       (w_pop),
      .o_pop_data  (w_fifo_data),
      .o_level     (level),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   assign wr_ready = ~w_fifo_full;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_load_bit  = w_fifo_data[WIDTH-1];
         assign w_load_rest = {w_fifo_data[WIDTH-2:0], 1'b0};
         assign w_next_bit  = r_shreg[WIDTH-1];
         assign w_next_rest = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_load_bit  = w_fifo_data[0];
         assign w_load_rest = {1'b0, w_fifo_data[WIDTH-1:1]};
         assign w_next_bit  = r_shreg[0];
         assign w_next_rest = {1'b0, r_shreg[WIDTH-1:1]};
      end
   endgenerate

   // The last bit of the current word is on ser_out when cnt reaches WIDTH-1.
   assign w_last = (r_cnt == c_LAST);

   // State register (also holds the datapath and the registered outputs).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_shreg      <= '0;
         r_cnt        <= '0;
         r_ser_out    <= IDLE_BIT;
         r_ser_active <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shreg      <= w_shreg_nxt;
         r_cnt        <= w_cnt_nxt;
         r_ser_out    <= w_ser_out_nxt;
         r_ser_active <= w_ser_active_nxt;
      end
   end

   // Next-state logic. Popping on the last bit of a word loads the next word
   // on the same edge, which is what keeps consecutive words gap-free.
   always_comb begin
      w_state_nxt = IDLE;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_last) begin
               if (!w_fifo_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = SHIFT;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Output / datapath logic: values registered on the next edge.
   always_comb begin
      w_shreg_nxt      = r_shreg;
      w_cnt_nxt        = '0;
      w_ser_out_nxt    = IDLE_BIT;
      w_ser_active_nxt = 1'b0;
      if (w_pop) begin
         w_ser_out_nxt    = w_load_bit;
         w_shreg_nxt      = w_load_rest;
         w_cnt_nxt        = '0;
         w_ser_active_nxt = 1'b1;
      end else if ((r_state == SHIFT) && !w_last) begin
         w_ser_out_nxt    = w_next_bit;
         w_shreg_nxt      = w_next_rest;
         w_cnt_nxt        = r_cnt + 1'b1;
         w_ser_active_nxt = 1'b1;
      end
   end

   assign ser_out    = r_ser_out;
   assign ser_active = r_ser_active;

endmodule : serial_bit_source
`default_nettype wire

// File: tb/tb_serial_bit_source.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_bit_source                                          |
// | Purpose  : Scoreboard bench. Accepted words are expanded into their      |
// |            expected bit sequence and queued; a monitor pops one bit each |
// |            time the DUT flags a data bit. A word-level occupancy model   |
// |            predicts wr_ready, level and ser_active every cycle. A second |
// |            instance covers LSB-first with a high idle level.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_serial_bit_source;

   localparam int c_WIDTH = 8;
   localparam int c_DEPTH = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;

   // main instance: MSB first, idle low
   logic [7:0] wr_data  = '0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic       ser_out;
   logic       ser_active;
   logic [2:0] level;

   // second instance: LSB first, idle high
   logic [7:0] wr_data2  = '0;
   logic       wr_valid2 = 1'b0;
   logic       wr_ready2;
   logic       ser_out2;
   logic       ser_active2;
   logic [2:0] level2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_bit_source #(
      .WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
   ) u_dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .ser_out(ser_out), .ser_active(ser_active),
      .level(level)
   );

   serial_bit_source #(
      .WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
   ) u_dut_lsb (
      .clk(clk), .reset(reset), .wr_data(wr_data2), .wr_valid(wr_valid2),
      .wr_ready(wr_ready2), .ser_out(ser_out2), .ser_active(ser_active2),
      .level(level2)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_fifo   : words waiting in the buffer
   // m_left   : data bits of the current word still to appear on ser_out,
   //            counting the one being shown
   // m_bits   : scoreboard of every expected data bit in transmit order
   logic [7:0] m_fifo[$];
   int         m_left = 0;
   bit         m_bits[$];
   bit         m_acc = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_fifo.delete();
         m_bits.delete();
         m_left = 0;
         m_acc  = 1'b0;
      end else begin
         m_acc = wr_valid && (m_fifo.size() < c_DEPTH);
         // the shifter takes a new word when it is idle or showing its last bit
         if ((m_left <= 1) && (m_fifo.size() > 0)) begin
            void'(m_fifo.pop_front());
            m_left = c_WIDTH;
         end else if (m_left > 0) begin
            m_left--;
         end
         if (m_acc) begin
            m_fifo.push_back(wr_data);
            for (int i = c_WIDTH - 1; i >= 0; i--) m_bits.push_back(wr_data[i]);
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      bit b;
      if (reset) begin
         check("wr_ready", {31'd0, wr_ready}, {31'd0, m_fifo.size() < c_DEPTH});
         check("level", {29'd0, level}, m_fifo.size());
         check("ser_active", {31'd0, ser_active}, {31'd0, m_left > 0});
         if (ser_active) begin
            if (m_bits.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL ser_out: data bit %0b with empty scoreboard at %0t",
                        ser_out, $time);
            end else begin
               b = m_bits.pop_front();
               check("ser_out", {31'd0, ser_out}, {31'd0, b});
            end
         end else begin
            check("ser_idle", {31'd0, ser_out}, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      int g = 0;
      wr_data  = d;
      wr_valid = 1'b1;
      do begin
         @(negedge clk);
         g++;
      end while (!m_acc && g < 200);
      if (!m_acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: word %0h not accepted after %0d cycles", d, g);
      end
      wr_valid = 1'b0;
   endtask

   bit lsb_o[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   bit lsb_a[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      int g;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ser_out", {31'd0, ser_out}, 32'd0);
      check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("reset_level", {29'd0, level}, 32'd0);
      check("reset_lsb_idle", {31'd0, ser_out2}, 32'd1);
      reset = 1'b1;

      // LSB-first, idle-high instance: one word 8'h01
      wr_data2  = 8'h01;
      wr_valid2 = 1'b1;
      @(negedge clk);
      wr_valid2 = 1'b0;
      for (int i = 0; i < 11; i++) begin
         check("lsb_ser_out", {31'd0, ser_out2}, {31'd0, lsb_o[i]});
         check("lsb_active", {31'd0, ser_active2}, {31'd0, lsb_a[i]});
         @(negedge clk);
      end

      // single word
      send(8'b1010_1100);
      idle(12);

      // two back-to-back words
      send(8'hA5);
      send(8'h3C);
      idle(20);

      // six words into a busy shifter: the sixth waits for a pop
      for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)));
      idle(60);

      // reset in the middle of a word
      send(8'hFF);
      g = 0;
      while (!ser_active && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("shifter_started", {31'd0, ser_active}, 32'd1);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midreset_ser_out", {31'd0, ser_out}, 32'd0);
      check("midreset_active", {31'd0, ser_active}, 32'd0);
      check("midreset_level", {29'd0, level}, 32'd0);
      check("midreset_ready", {31'd0, wr_ready}, 32'd1);
      idle(2);
      reset = 1'b1;
      idle(12);

      // randomized traffic with busy and sparse phases
      for (int p = 0; p < 8; p++) begin
         int pct;
         pct = (p % 2 == 0) ? 90 : 15;
         repeat (50) begin
            wr_valid = ($urandom_range(99) < pct);
            wr_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      wr_valid = 1'b0;
      idle(80);

      check("scoreboard_drained", m_bits.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_serial_bit_source
`default_nettype wire
